// File: rtl/safe_attempt_sequencer_pkg.sv
// safe_attempt_sequencer_pkg: lock stage codes, FSM encodings and stage helpers
package safe_attempt_sequencer_pkg;

    localparam logic [3:0] STG_SETUP = 4'b0000;
    localparam logic [3:0] STG_E1    = 4'b0001;
    localparam logic [3:0] STG_E2    = 4'b0011;
    localparam logic [3:0] STG_E3    = 4'b0111;
    localparam logic [3:0] STG_OPEN  = 4'b1111;

    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] PRESS   = 3'd1;
    localparam logic [2:0] SETTLE  = 3'd2;
    localparam logic [2:0] JUDGE   = 3'd3;
    localparam logic [2:0] LOCKOUT = 3'd4;
    localparam logic [2:0] RELEASE = 3'd5;

    function automatic logic is_entry(input logic [3:0] s);
        return s == STG_E1 || s == STG_E2 || s == STG_E3;
    endfunction

    function automatic logic [2:0] popcount4(input logic [3:0] v);
        return {2'b0, v[0]} + {2'b0, v[1]} + {2'b0, v[2]} + {2'b0, v[3]};
    endfunction

endpackage

// File: rtl/safe_attempt_sequencer_if.sv
// safe_attempt_sequencer_if: sequencer <-> lock link (stage code in, action pulse out)
interface safe_attempt_sequencer_if;
    logic [3:0] stage;
    logic       action_n;
    modport master (input stage, output action_n);
    modport slave  (output stage, input action_n);
endinterface

// File: rtl/safe_attempt_sequencer_key_debouncer.sv
// key_debouncer: 2-flop sync of key_n, level adopted after DB_CYC stable samples, one-cycle press on 1->0
module key_debouncer
#(
    parameter int DB_CYC = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key_n_i,
    output logic level_o,
    output logic press_o
);

    localparam int CW = $clog2(DB_CYC + 1);

    logic [1:0]    sync_q;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          level_q, level_d, press_q, press_d, adopt;

    always_comb begin
        adopt   = sync_q[1] != level_q && cnt_q == CW'(DB_CYC - 1);
        cnt_d   = (sync_q[1] == level_q || adopt) ? '0 : cnt_q + 1'b1;
        level_d = adopt ? sync_q[1] : level_q;
        press_d = adopt && !sync_q[1];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q  <= 2'b11;
            cnt_q   <= '0;
            level_q <= 1'b1;
            press_q <= 1'b0;
        end else begin
            sync_q  <= {sync_q[0], key_n_i};
            cnt_q   <= cnt_d;
            level_q <= level_d;
            press_q <= press_d;
        end
    end

    assign level_o = level_q;
    assign press_o = press_q;

endmodule

// File: rtl/safe_attempt_sequencer.sv
// safe_attempt_sequencer: forwards debounced ENTER presses to the lock, judges the stage
// outcome, tracks consecutive fails and enforces an escalating lockout.
module safe_attempt_sequencer
    import safe_attempt_sequencer_pkg::*;
#(
    parameter int DB_CYC     = 16,
    parameter int PULSE_CYC  = 4,
    parameter int SETTLE_CYC = 8,
    parameter int MAX_FAILS  = 3,
    parameter int LOCK_CYC   = 1000,
    parameter int LOCK_W     = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    key_n_i,
    safe_attempt_sequencer_if.master lk,
    output logic                    locked_out_o,
    output logic [3:0]              fail_streak_o,
    output logic [1:0]              lock_level_o,
    output logic [LOCK_W+2:0]       lock_remaining_o,
    output logic [7:0]              dropped_o
);

    localparam int RW = LOCK_W + 3;
    localparam int CW = $clog2((PULSE_CYC > SETTLE_CYC ? PULSE_CYC : SETTLE_CYC) + 1);
    localparam logic [RW-1:0] LOCK_BASE = RW'(LOCK_CYC);

    logic          key_level, press;
    logic [2:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [3:0]    prev_q, prev_d, streak_q, streak_d;
    logic [1:0]    level_q, level_d;
    logic [RW-1:0] rem_q, rem_d;
    logic [7:0]    drop_q, drop_d;
    logic [2:0]    pc_now, pc_prev;

    key_debouncer #(.DB_CYC(DB_CYC)) u_db (
        .clk     (clk),
        .rst_n   (rst_n),
        .key_n_i (key_n_i),
        .level_o (key_level),
        .press_o (press)
    );

    assign pc_now  = popcount4(lk.stage);
    assign pc_prev = popcount4(prev_q);

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        prev_d   = prev_q;
        streak_d = streak_q;
        level_d  = level_q;
        rem_d    = rem_q;
        drop_d   = drop_q;
        case (state_q)
            IDLE: if (press) begin
                state_d = PRESS;
                prev_d  = lk.stage;
            end
            PRESS: begin
                cnt_d   = cnt_q == CW'(PULSE_CYC - 1) ? '0 : cnt_q + 1'b1;
                state_d = cnt_q == CW'(PULSE_CYC - 1) ? SETTLE : PRESS;
            end
            SETTLE: begin
                cnt_d   = cnt_q == CW'(SETTLE_CYC - 1) ? '0 : cnt_q + 1'b1;
                state_d = cnt_q == CW'(SETTLE_CYC - 1) ? JUDGE : SETTLE;
            end
            JUDGE: begin
                state_d = RELEASE;
                if (prev_q == STG_OPEN) begin
                    streak_d = '0;
                    level_d  = '0;
                end else if (is_entry(prev_q)) begin
                    if (pc_now == pc_prev) begin
                        if (streak_q == 4'(MAX_FAILS - 1)) begin
                            streak_d = '0;
                            rem_d    = LOCK_BASE << level_q;
                            level_d  = level_q == 2'd3 ? 2'd3 : level_q + 2'd1;
                            state_d  = LOCKOUT;
                        end else begin
                            streak_d = streak_q + 4'd1;
                        end
                    end else if (pc_now > pc_prev) begin
                        streak_d = '0;
                        level_d  = lk.stage == STG_OPEN ? 2'd0 : level_q;
                    end
                end
            end
            LOCKOUT: begin
                drop_d  = press && drop_q != 8'hff ? drop_q + 8'd1 : drop_q;
                rem_d   = rem_q == '0 ? rem_q : rem_q - 1'b1;
                state_d = rem_q == '0 ? RELEASE : LOCKOUT;
            end
            RELEASE: state_d = key_level ? IDLE : RELEASE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            prev_q   <= STG_SETUP;
            streak_q <= '0;
            level_q  <= '0;
            rem_q    <= '0;
            drop_q   <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            prev_q   <= prev_d;
            streak_q <= streak_d;
            level_q  <= level_d;
            rem_q    <= rem_d;
            drop_q   <= drop_d;
        end
    end

    // Decoded straight from state so an async reset releases the lock input immediately
    assign lk.action_n      = state_q != PRESS;
    assign locked_out_o     = state_q == LOCKOUT;
    assign fail_streak_o    = streak_q;
    assign lock_level_o     = level_q;
    assign lock_remaining_o = rem_q;
    assign dropped_o        = drop_q;

endmodule

// File: tb/tb_safe_attempt_sequencer.sv
// tb_safe_attempt_sequencer: scoreboard bench; each forwarded press queues its expected
// pulse length and post-judgement counters, checked when the pulse is observed.
module tb_safe_attempt_sequencer;
    import safe_attempt_sequencer_pkg::*;

    localparam int DB = 4, PC = 2, SC = 4, MF = 3, LC = 20, LW = 16;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              key_n = 1'b1;
    logic              locked_out;
    logic [3:0]        fail_streak;
    logic [1:0]        lock_level;
    logic [LW+2:0]     lock_remaining;
    logic [7:0]        dropped;

    safe_attempt_sequencer_if lk();

    safe_attempt_sequencer #(
        .DB_CYC(DB), .PULSE_CYC(PC), .SETTLE_CYC(SC),
        .MAX_FAILS(MF), .LOCK_CYC(LC), .LOCK_W(LW)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .key_n_i          (key_n),
        .lk               (lk),
        .locked_out_o     (locked_out),
        .fail_streak_o    (fail_streak),
        .lock_level_o     (lock_level),
        .lock_remaining_o (lock_remaining),
        .dropped_o        (dropped)
    );

    always #5 clk = ~clk;

    typedef struct {
        int streak;
        int level;
        int locked;
        int rem;
    } exp_t;

    exp_t sb[$];
    exp_t cur;
    int checks = 0, errors = 0, pulses = 0, low_len = 0, wait_n = 0;
    int m_streak = 0, m_level = 0;

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic model(input logic [3:0] p, input logic [3:0] n);
        exp_t e;
        e.locked = 0;
        e.rem = 0;
        if (p inside {4'b0001, 4'b0011, 4'b0111}) begin
            if ($countones(n) == $countones(p)) begin
                if (m_streak + 1 == MF) begin
                    m_streak = 0;
                    e.locked = 1;
                    e.rem = LC << m_level;
                    m_level = m_level == 3 ? 3 : m_level + 1;
                end else begin
                    m_streak++;
                end
            end else if ($countones(n) > $countones(p)) begin
                m_streak = 0;
                if (n == 4'b1111) m_level = 0;
            end
        end else if (p == 4'b1111) begin
            m_streak = 0;
            m_level = 0;
        end
        e.streak = m_streak;
        e.level = m_level;
        sb.push_back(e);
    endtask

    // Pulse end is PC+1 after the press; judged values appear SC+1 cycles later
    always @(negedge clk) begin
        if (!rst_n) begin
            low_len = 0;
            wait_n = 0;
        end else if (!lk.action_n) begin
            low_len++;
        end else if (low_len > 0) begin
            pulses++;
            check("pulse_len", low_len, PC);
            low_len = 0;
            wait_n = SC + 1;
        end else if (wait_n > 0) begin
            wait_n--;
            if (wait_n == 0) begin
                check("pulse_expected", int'(sb.size() > 0), 1);
                if (sb.size() > 0) begin
                    cur = sb.pop_front();
                    check("fail_streak", int'(fail_streak), cur.streak);
                    check("lock_level", int'(lock_level), cur.level);
                    check("locked_out", int'(locked_out), cur.locked);
                    check("lock_remaining", int'(lock_remaining), cur.rem);
                end
            end
        end
    end

    task automatic press_key(input int lo, input int hi);
        key_n = 1'b0;
        repeat (lo) @(negedge clk);
        key_n = 1'b1;
        repeat (hi) @(negedge clk);
    endtask

    task automatic fwd(input logic [3:0] p, input logic [3:0] n, input int gap);
        model(p, n);
        lk.stage = p;
        key_n = 1'b0;
        repeat (6) @(negedge clk);
        key_n = 1'b1;
        repeat (3) @(negedge clk);
        lk.stage = n;
        repeat (3 + gap) @(negedge clk);
    endtask

    task automatic wait_unlock(input int bound);
        for (int i = 0; i < bound && locked_out; i++) @(negedge clk);
        check("unlock", int'(locked_out), 0);
    endtask

    task automatic check_cleared(input string tag);
        check({tag, "_action"}, int'(lk.action_n), 1);
        check({tag, "_locked"}, int'(locked_out), 0);
        check({tag, "_streak"}, int'(fail_streak), 0);
        check({tag, "_level"}, int'(lock_level), 0);
        check({tag, "_rem"}, int'(lock_remaining), 0);
        check({tag, "_dropped"}, int'(dropped), 0);
    endtask

    initial begin
        int n;
        lk.stage = STG_SETUP;
        repeat (3) @(negedge clk);
        check_cleared("reset");
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            key_n = 1'b0;
            @(negedge clk);
            key_n = 1'b1;
            @(negedge clk);
        end
        model(STG_SETUP, STG_SETUP);
        press_key(10, 15);
        check("glitch_pulses", pulses, 1);
        fwd(STG_E1, STG_E1, 10);
        fwd(STG_E1, STG_E1, 10);
        fwd(STG_E1, STG_E1, 0);
        press_key(6, 6);
        press_key(6, 6);
        wait_unlock(60);
        check("dropped", int'(dropped), 2);
        check("dropped_not_forwarded", pulses, 4);
        repeat (10) @(negedge clk);
        fwd(STG_E1, STG_E1, 10);
        fwd(STG_E1, STG_E1, 10);
        fwd(STG_E1, STG_E1, 10);
        wait_unlock(100);
        repeat (10) @(negedge clk);
        fwd(STG_E1, STG_E1, 10);
        fwd(STG_E1, STG_E2, 10);
        fwd(STG_E3, STG_OPEN, 10);
        fwd(STG_E1, STG_E1, 10);
        fwd(STG_E2, STG_E1, 10);
        n = pulses;
        model(STG_OPEN, STG_OPEN);
        lk.stage = STG_OPEN;
        key_n = 1'b0;
        repeat (200) @(negedge clk);
        check("held_pulses", pulses, n + 1);
        key_n = 1'b1;
        repeat (15) @(negedge clk);
        check("held_release_pulses", pulses, n + 1);
        fwd(STG_SETUP, STG_SETUP, 10);
        check("after_hold_pulses", pulses, n + 2);
        lk.stage = STG_E1;
        key_n = 1'b0;
        for (int i = 0; i < 30 && lk.action_n; i++) @(negedge clk);
        check("press_before_reset", int'(lk.action_n), 0);
        rst_n = 1'b0;
        #1;
        check("async_release", int'(lk.action_n), 1);
        key_n = 1'b1;
        sb.delete();
        m_streak = 0;
        m_level = 0;
        repeat (3) @(negedge clk);
        check_cleared("midpulse_reset");
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        fwd(STG_E1, STG_E1, 10);
        repeat (5) @(negedge clk);
        check("sb_drained", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
